// File: rtl/bbq_resp_merger.sv
// bbq_resp_merger
// Merges the two BBQ response lanes: counts enqueue acks and collects dequeue
// results into a small in-order result FIFO, while tracking dequeues in flight
// so the request router can be throttled before the FIFO would overflow.
//
// Ports
//   clk, rst (async, active-low)
//   issue_deq                   dequeue op issued to the BBQ this cycle
//   in_{0,1}_valid/op_type/he_data/he_priority   response lanes
//                               op_type 2'b00 = enqueue ack, anything else = dequeue result
//   bbq_rdy                     issue permission back to the router
//   out_valid/out_ready, out_data/out_priority   result stream (FIFO head)
//   enq_ack_cnt                 saturating enqueue-ack counter
//   err_unexpected              sticky: dequeue result without credit, or dropped on full
module bbq_resp_merger #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned PRIOR_WIDTH = 6,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_deq,
    input  logic                   in_0_valid,
    input  logic [1:0]             in_0_op_type,
    input  logic [DWIDTH-1:0]      in_0_he_data,
    input  logic [PRIOR_WIDTH-1:0] in_0_he_priority,
    input  logic                   in_1_valid,
    input  logic [1:0]             in_1_op_type,
    input  logic [DWIDTH-1:0]      in_1_he_data,
    input  logic [PRIOR_WIDTH-1:0] in_1_he_priority,
    output logic                   bbq_rdy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      out_data,
    output logic [PRIOR_WIDTH-1:0] out_priority,
    output logic [CNT_WIDTH-1:0]   enq_ack_cnt,
    output logic                   err_unexpected
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [1:0] HEAP_OP_ENQUE = 2'b00;

    logic [DWIDTH-1:0]      data_q [FIFO_DEPTH];
    logic [DWIDTH-1:0]      data_d [FIFO_DEPTH];
    logic [PRIOR_WIDTH-1:0] prio_q [FIFO_DEPTH];
    logic [PRIOR_WIDTH-1:0] prio_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
    logic [OCC_W-1:0]       count_q, count_d, in_flight_q, in_flight_d;
    logic [CNT_WIDTH-1:0]   enq_cnt_q, enq_cnt_d;
    logic [CNT_WIDTH:0]     enq_sum;
    logic                   err_q, err_d;

    logic        ack0, ack1, res0, res1, wr0, wr1, pop, drop;
    int unsigned space, nres;
    int          infl_tmp;

    assign ack0 = in_0_valid && (in_0_op_type == HEAP_OP_ENQUE);
    assign ack1 = in_1_valid && (in_1_op_type == HEAP_OP_ENQUE);
    assign res0 = in_0_valid && (in_0_op_type != HEAP_OP_ENQUE);
    assign res1 = in_1_valid && (in_1_op_type != HEAP_OP_ENQUE);

    assign out_valid      = (count_q != '0);
    assign pop            = out_valid && out_ready;
    assign out_data       = data_q[rd_ptr_q];
    assign out_priority   = prio_q[rd_ptr_q];
    assign enq_ack_cnt    = enq_cnt_q;
    assign err_unexpected = err_q;
    assign bbq_rdy        = (32'(count_q) + 32'(in_flight_q)) < FIFO_DEPTH;

    always_comb begin
        // A pop this cycle frees its slot before the pushes are placed.
        space   = FIFO_DEPTH - 32'(count_q) + 32'(pop);
        wr0     = res0 && (space >= 32'd1);
        wr1     = res1 && (space >= (wr0 ? 32'd2 : 32'd1));
        drop    = (res0 && !wr0) || (res1 && !wr1);
        nres    = 32'(res0) + 32'(res1);
        wr1_ptr = wr_ptr_q + PTR_W'(wr0);

        data_d = data_q;
        prio_d = prio_q;
        if (wr0) begin
            data_d[wr_ptr_q] = in_0_he_data;
            prio_d[wr_ptr_q] = in_0_he_priority;
        end
        if (wr1) begin
            data_d[wr1_ptr] = in_1_he_data;
            prio_d[wr1_ptr] = in_1_he_priority;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(wr0) + PTR_W'(wr1);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + OCC_W'(wr0) + OCC_W'(wr1) - OCC_W'(pop);

        // Clamp at 0 (spurious results) and at FIFO_DEPTH (issues past bbq_rdy).
        infl_tmp = int'(in_flight_q) + int'(issue_deq) - int'(nres);
        if (infl_tmp < 0) begin
            in_flight_d = '0;
        end else if (infl_tmp > int'(FIFO_DEPTH)) begin
            in_flight_d = OCC_W'(FIFO_DEPTH);
        end else begin
            in_flight_d = OCC_W'(infl_tmp);
        end

        enq_sum   = {1'b0, enq_cnt_q} + (CNT_WIDTH+1)'(ack0) + (CNT_WIDTH+1)'(ack1);
        enq_cnt_d = enq_sum[CNT_WIDTH] ? '1 : enq_sum[CNT_WIDTH-1:0];

        // More results than outstanding credit means at least one was unexpected.
        err_d = err_q || drop || (nres > 32'(in_flight_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                prio_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            enq_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            prio_q      <= prio_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            enq_cnt_q   <= enq_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_bbq_resp_merger.sv
// Bench for bbq_resp_merger: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bbq_resp_merger;

    localparam int DEPTH = 4;
    localparam logic [1:0] ENQ = 2'b00;
    localparam logic [1:0] DEQ = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_deq;
    logic        v0, v1;
    logic [1:0]  op0, op1;
    logic [31:0] d0, d1;
    logic [5:0]  p0, p1;
    logic        bbq_rdy, out_valid, out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_priority;
    logic [15:0] enq_ack_cnt;
    logic        err_unexpected;

    int checks   = 0;
    int failures = 0;

    bbq_resp_merger dut (
        .clk              (clk),
        .rst              (rst_n),
        .issue_deq        (issue_deq),
        .in_0_valid       (v0),
        .in_0_op_type     (op0),
        .in_0_he_data     (d0),
        .in_0_he_priority (p0),
        .in_1_valid       (v1),
        .in_1_op_type     (op1),
        .in_1_he_data     (d1),
        .in_1_he_priority (p1),
        .bbq_rdy          (bbq_rdy),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_priority     (out_priority),
        .enq_ack_cnt      (enq_ack_cnt),
        .err_unexpected   (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_data[$];
    logic [5:0]  m_prio[$];
    int          m_infl;
    int          m_cnt;
    bit          m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data.delete();
            m_prio.delete();
            m_infl = 0;
            m_cnt  = 0;
            m_err  = 0;
        end else begin
            int nres;
            int acks;
            nres = 0;
            acks = 0;
            if (v0) begin if (op0 == ENQ) acks++; else nres++; end
            if (v1) begin if (op1 == ENQ) acks++; else nres++; end
            if (nres > m_infl) m_err = 1;
            if (m_data.size() != 0 && out_ready) begin
                void'(m_data.pop_front());
                void'(m_prio.pop_front());
            end
            if (v0 && op0 != ENQ) begin
                if (m_data.size() < DEPTH) begin m_data.push_back(d0); m_prio.push_back(p0); end
                else m_err = 1;
            end
            if (v1 && op1 != ENQ) begin
                if (m_data.size() < DEPTH) begin m_data.push_back(d1); m_prio.push_back(p1); end
                else m_err = 1;
            end
            m_infl = m_infl + int'(issue_deq) - nres;
            if (m_infl < 0) m_infl = 0;
            if (m_infl > DEPTH) m_infl = DEPTH;
            m_cnt = m_cnt + acks;
            if (m_cnt > 65535) m_cnt = 65535;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out_valid", out_valid, m_data.size() != 0);
            chk("m_bbq_rdy", bbq_rdy, (m_data.size() + m_infl) < DEPTH);
            chk("m_enq_ack_cnt", enq_ack_cnt, m_cnt);
            chk("m_err", err_unexpected, m_err);
            if (m_data.size() != 0) begin
                chk("m_out_data", out_data, m_data[0]);
                chk("m_out_priority", out_priority, m_prio[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs at the falling edge; return 2 time units after the rising edge.
    task automatic step(input logic iss, input logic rdy,
                        input logic a_v, input logic [1:0] a_op, input logic [31:0] a_d,
                        input logic [5:0] a_p,
                        input logic b_v, input logic [1:0] b_op, input logic [31:0] b_d,
                        input logic [5:0] b_p);
        @(negedge clk);
        issue_deq = iss; out_ready = rdy;
        v0 = a_v; op0 = a_op; d0 = a_d; p0 = a_p;
        v1 = b_v; op1 = b_op; d1 = b_d; p1 = b_p;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, rdy, 1'b0, ENQ, 32'h0, 6'h0, 1'b0, ENQ, 32'h0, 6'h0);
    endtask

    task automatic issue(input logic rdy);
        step(1'b1, rdy, 1'b0, ENQ, 32'h0, 6'h0, 1'b0, ENQ, 32'h0, 6'h0);
    endtask

    task automatic clear_inputs();
        issue_deq = 0; out_ready = 0;
        v0 = 0; op0 = ENQ; d0 = 0; p0 = 0;
        v1 = 0; op1 = ENQ; d1 = 0; p1 = 0;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst_n = 0;
        clear_inputs();
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bbq_rdy", bbq_rdy, 1);
        chk("rst_enq_cnt", enq_ack_cnt, 0);
        chk("rst_err", err_unexpected, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_prio", out_priority, 0);
        rst_n = 1;

        // Enqueue acks: lane 0, lane 1, then both.
        step(0, 0, 1, ENQ, 32'h0, 6'h0, 0, ENQ, 32'h0, 6'h0);
        step(0, 0, 0, ENQ, 32'h0, 6'h0, 1, ENQ, 32'h0, 6'h0);
        step(0, 0, 1, ENQ, 32'h0, 6'h0, 1, ENQ, 32'h0, 6'h0);
        chk("ack_cnt4", enq_ack_cnt, 4);
        chk("ack_no_valid", out_valid, 0);

        // Two dequeues, both results in one cycle, lane 0 first.
        issue(1);
        issue(1);
        step(0, 1, 1, DEQ, 32'hA1, 6'd3, 1, DEQ, 32'hB2, 6'd5);
        chk("merge_first_data", out_data, 32'hA1);
        chk("merge_first_prio", out_priority, 3);
        idle(1);
        chk("merge_second_data", out_data, 32'hB2);
        chk("merge_second_prio", out_priority, 5);
        idle(1);
        chk("merge_empty", out_valid, 0);
        chk("merge_no_err", err_unexpected, 0);

        // Result with no dequeue in flight: flagged, still delivered, flag sticks.
        step(0, 0, 1, DEQ, 32'h37, 6'd7, 0, ENQ, 32'h0, 6'h0);
        chk("unexp_err", err_unexpected, 1);
        chk("unexp_valid", out_valid, 1);
        chk("unexp_data", out_data, 32'h37);
        idle(1);
        chk("unexp_popped", out_valid, 0);
        chk("unexp_sticky", err_unexpected, 1);

        // Credit throttling with a stalled consumer.
        issue(0);
        issue(0);
        issue(0);
        chk("thr_rdy_after3", bbq_rdy, 1);
        issue(0);
        chk("thr_rdy_after4", bbq_rdy, 0);
        step(0, 0, 1, DEQ, 32'h1, 6'd1, 1, DEQ, 32'h2, 6'd2);
        step(0, 0, 1, DEQ, 32'h3, 6'd3, 1, DEQ, 32'h4, 6'd4);
        chk("thr_full_valid", out_valid, 1);
        chk("thr_full_rdy", bbq_rdy, 0);
        idle(1);
        chk("thr_pop_rdy", bbq_rdy, 1);
        chk("thr_pop_data", out_data, 32'h2);
        repeat (4) idle(1);
        chk("thr_drained", out_valid, 0);

        // Full FIFO: a result with credit is dropped and flagged; a pop makes room.
        reset_pulse();
        chk("drop_err_clear", err_unexpected, 0);
        repeat (4) issue(0);
        step(0, 0, 1, DEQ, 32'h11, 6'd1, 1, DEQ, 32'h22, 6'd2);
        step(0, 0, 1, DEQ, 32'h33, 6'd3, 1, DEQ, 32'h44, 6'd4);
        issue(0);
        chk("drop_issue_past_rdy", bbq_rdy, 0);
        step(0, 0, 1, DEQ, 32'h55, 6'd5, 0, ENQ, 32'h0, 6'h0);
        chk("drop_err_set", err_unexpected, 1);
        chk("drop_head", out_data, 32'h11);
        issue(0);
        step(0, 1, 1, DEQ, 32'h66, 6'd6, 0, ENQ, 32'h0, 6'h0);
        chk("pushpop_head", out_data, 32'h22);
        chk("pushpop_valid", out_valid, 1);
        repeat (5) idle(1);
        chk("pushpop_drained", out_valid, 0);

        // Asynchronous reset mid-cycle with two entries queued.
        reset_pulse();
        repeat (2) issue(0);
        step(0, 0, 1, DEQ, 32'h77, 6'd7, 1, DEQ, 32'h88, 6'd8);
        chk("arst_pre_valid", out_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 0;
        v0 = 1; op0 = DEQ; d0 = 32'h99; p0 = 6'd9;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_rdy", bbq_rdy, 1);
        chk("arst_data", out_data, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        clear_inputs();
        idle(0);
        chk("arst_ignored_resp", out_valid, 0);

        // Counter saturation via double acks.
        reset_pulse();
        for (int i = 0; i < 32766; i++) begin
            step(0, 0, 1, ENQ, 32'h0, 6'h0, 1, ENQ, 32'h0, 6'h0);
        end
        chk("sat_pre", enq_ack_cnt, 16'hFFFC);
        step(0, 0, 1, ENQ, 32'h0, 6'h0, 1, ENQ, 32'h0, 6'h0);
        chk("sat_fffe", enq_ack_cnt, 16'hFFFE);
        step(0, 0, 1, ENQ, 32'h0, 6'h0, 1, ENQ, 32'h0, 6'h0);
        chk("sat_ffff", enq_ack_cnt, 16'hFFFF);
        step(0, 0, 1, ENQ, 32'h0, 6'h0, 1, ENQ, 32'h0, 6'h0);
        chk("sat_hold", enq_ack_cnt, 16'hFFFF);
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
